conv_encoder: RTL and testbench

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/conv_encoder.sv | 120 ++++++++++++
 tb/tb_conv_encoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// Rate-1/2, constraint-length-7 convolutional encoder with a one-deep output
// register, valid/ready handshakes on both sides and optional zero-tail
// termination at frame end.
module conv_encoder #(
  parameter logic [6:0] G0        = 7'o171,
  parameter logic [6:0] G1        = 7'o133,
  parameter bit         TERMINATE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       data_i,
  input  logic       last_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [1:0] data_o,
  output logic       last_o
);

  typedef enum logic {RUN = 1'b0, TAIL = 1'b1} fsm_t;

  // Code symbol {c1,c0} for input bit u on the pre-update state s.
  function automatic logic [1:0] encode(input logic u, input logic [5:0] s);
    logic [6:0] v;
    v = {u, s};
    return {^(G1 & v), ^(G0 & v)};
  endfunction

  fsm_t       fsm_p1, fsm_nxt;
  logic [2:0] tcnt_p1, tcnt_nxt;
  logic [5:0] s_p1, s_nxt;
  logic       vld_p1, vld_nxt;
  logic [1:0] sym_p1, sym_nxt;
  logic       lst_p1, lst_nxt;
  logic       slot_free;
  logic       in_hs;

  // The output register can take a new symbol when empty or being drained.
  assign slot_free = !vld_p1 || ready_i;
  assign ready_o   = (fsm_p1 == RUN) && slot_free;
  assign in_hs     = valid_i && ready_o;

  assign valid_o = vld_p1;
  assign data_o  = sym_p1;
  assign last_o  = lst_p1;

  // Next-state logic: input encoding in RUN, zero-tail generation in TAIL.
  always_comb begin
    fsm_nxt  = fsm_p1;
    tcnt_nxt = tcnt_p1;
    s_nxt    = s_p1;
    vld_nxt  = vld_p1;
    sym_nxt  = sym_p1;
    lst_nxt  = lst_p1;
    if (flush_i) begin
      fsm_nxt  = RUN;
      tcnt_nxt = 3'd0;
      s_nxt    = 6'd0;
      vld_nxt  = 1'b0;
      lst_nxt  = 1'b0;
    end else if (fsm_p1 == RUN) begin
      if (in_hs) begin
        vld_nxt = 1'b1;
        sym_nxt = encode(data_i, s_p1);
        s_nxt   = {data_i, s_p1[5:1]};
        lst_nxt = 1'b0;
        if (last_i) begin
          if (TERMINATE) begin
            fsm_nxt  = TAIL;
            tcnt_nxt = 3'd0;
          end else begin
            // Truncated frame: restart from the all-zero state.
            lst_nxt = 1'b1;
            s_nxt   = 6'd0;
          end
        end
      end else if (slot_free) begin
        vld_nxt = 1'b0;
      end
    end else begin
      // Tail bits only advance when the output register frees up, so
      // backpressure stalls the tail without loss or duplication.
      if (slot_free) begin
        vld_nxt = 1'b1;
        sym_nxt = encode(1'b0, s_p1);
        s_nxt   = {1'b0, s_p1[5:1]};
        lst_nxt = (tcnt_p1 == 3'd5);
        if (tcnt_p1 == 3'd5) begin
          fsm_nxt  = RUN;
          tcnt_nxt = 3'd0;
        end else begin
          tcnt_nxt = tcnt_p1 + 3'd1;
        end
      end
    end
  end

  // State, tail counter and output register; reset clears everything,
  // including the symbol, so outputs read zero after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_p1  <= RUN;
      tcnt_p1 <= 3'd0;
      s_p1    <= 6'd0;
      vld_p1  <= 1'b0;
      sym_p1  <= 2'b00;
      lst_p1  <= 1'b0;
    end else begin
      fsm_p1  <= fsm_nxt;
      tcnt_p1 <= tcnt_nxt;
      s_p1    <= s_nxt;
      vld_p1  <= vld_nxt;
      sym_p1  <= sym_nxt;
      lst_p1  <= lst_nxt;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: impulse response, truncation, random frame under
// backpressure against a convolution reference model, flush and reset.
module tb_conv_encoder;

  localparam logic [6:0] TG0 = 7'o171;
  localparam logic [6:0] TG1 = 7'o133;

  logic       clk;
  logic       rst_ni, flush_i, valid_i, data_i, last_i, ready_i;
  logic       ready_o, valid_o, last_o;
  logic [1:0] data_o;
  logic       ready_b, valid_b, last_b;
  logic [1:0] data_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [1:0] imp [7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};

  logic       bits [256];
  int         flen;
  logic [2:0] exp_q [$];

  conv_encoder #(.G0(TG0), .G1(TG1), .TERMINATE(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_i(data_i), .last_i(last_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .last_o(last_o)
  );

  conv_encoder #(.G0(TG0), .G1(TG1), .TERMINATE(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_b), .data_i(data_i), .last_i(last_i), .valid_o(valid_b),
    .ready_i(ready_i), .data_o(data_b), .last_o(last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbol n of a zero-terminated frame as a direct convolution of the bit
  // sequence with the generator taps (tap 6 = newest bit).
  function automatic logic [1:0] ref_sym(input int n);
    logic c0, c1;
    c0 = 1'b0;
    c1 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (n - k >= 0 && n - k < flen && bits[n - k]) begin
        c0 ^= TG0[6 - k];
        c1 ^= TG1[6 - k];
      end
    end
    return {c1, c0};
  endfunction

  // Single 1-bit frame on the terminating encoder; checks all 7 symbols.
  task automatic impulse(input string tag);
    valid_i = 1'b1; data_i = 1'b1; last_i = 1'b1; ready_i = 1'b1; flush_i = 1'b0;
    #1;
    chk({tag, "_rdy_in"}, ready_o, 1);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      valid_i = 1'b0; last_i = 1'b0; data_i = 1'b0;
      #1;
      chk({tag, "_vld"}, valid_o, 1);
      chk({tag, "_sym"}, data_o, imp[j-1]);
      chk({tag, "_last"}, last_o, (j == 7));
      chk({tag, "_rdy"}, ready_o, (j == 7));
    end
  endtask

  initial begin
    int         idx, nsym, cyc;
    logic       stalled, hlst;
    logic [1:0] hsym;
    logic [2:0] e;

    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; data_i = 1'b0;
    last_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_vld", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_last", last_o, 0);
    rst_ni = 1'b1;
    #1;
    chk("rst_rdy", ready_o, 1);

    // Impulse on both encoders; the truncating one emits a single last symbol.
    valid_i = 1'b1; data_i = 1'b1; last_i = 1'b1;
    #1;
    chk("imp_rdy_in", ready_o, 1);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      valid_i = 1'b0; last_i = 1'b0; data_i = 1'b0;
      #1;
      chk("imp_vld", valid_o, 1);
      chk("imp_sym", data_o, imp[j-1]);
      chk("imp_last", last_o, (j == 7));
      chk("imp_rdy", ready_o, (j == 7));
      if (j == 1) begin
        chk("trunc_vld", valid_b, 1);
        chk("trunc_sym", data_b, 2'b11);
        chk("trunc_last", last_b, 1);
        chk("trunc_rdy", ready_b, 1);
        chk("trunc_state", u_b.s_p1, 0);
      end else if (j == 2) begin
        chk("trunc_idle", valid_b, 0);
      end
    end

    // Random 100-bit frame with random backpressure and input gaps.
    flen = 100;
    for (int i = 0; i < flen; i++) bits[i] = 1'($urandom_range(0, 1));
    exp_q.delete();
    for (int n = 0; n < flen + 6; n++) exp_q.push_back({(n == flen + 5), ref_sym(n)});
    idx = 0; nsym = 0; cyc = 0; stalled = 1'b0; hsym = 2'b00; hlst = 1'b0;
    while (nsym < flen + 6 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      ready_i = 1'($urandom_range(0, 1));
      valid_i = (idx < flen) && ($urandom_range(0, 3) != 0);
      data_i  = (idx < flen) ? bits[idx] : 1'b0;
      last_i  = (idx == flen - 1);
      #1;
      if (stalled) begin
        chk("hold_vld", valid_o, 1);
        chk("hold_sym", data_o, hsym);
        chk("hold_last", last_o, hlst);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bp_sym", data_o, e[1:0]);
          chk("bp_last", last_o, e[2]);
        end else begin
          chk("bp_extra", nsym, flen + 6);
        end
        nsym++;
      end
      stalled = valid_o && !ready_i;
      hsym = data_o;
      hlst = last_o;
      if (valid_i && ready_o) idx++;
    end
    valid_i = 1'b0; last_i = 1'b0;
    chk("bp_count", nsym, flen + 6);
    chk("bp_inputs", idx, flen);

    // Flush during tail with the consumer stalled.
    @(negedge clk);
    ready_i = 1'b1; valid_i = 1'b1; data_i = 1'b1; last_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; last_i = 1'b0; data_i = 1'b0;
    repeat (2) @(negedge clk);
    flush_i = 1'b1; ready_i = 1'b0;
    @(negedge clk);
    #1;
    chk("flush_vld", valid_o, 0);
    chk("flush_rdy", ready_o, 1);
    flush_i = 1'b0;
    impulse("post_flush");

    // Reset together with flush and valid input in the middle of a frame.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_i = 1'b1; data_i = 1'b1; last_i = 1'b0; ready_i = 1'b1;
    end
    @(negedge clk);
    rst_ni = 1'b0; flush_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_vld", valid_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_last", last_o, 0);
    rst_ni = 1'b1; flush_i = 1'b0; valid_i = 1'b0;
    #1;
    chk("mid_rst_rdy", ready_o, 1);
    impulse("post_rst");

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
